// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART transmitter peripheral: register word
// offsets (Addr[1:0]), CTRL/STATUS bit positions and FSM state encodings.
package uart_defs;

   // Word offsets within the 16-byte window (byte offsets 0x0/0x4/0x8/0xC)
   localparam logic [1:0] OFF_DATA    = 2'd0;
   localparam logic [1:0] OFF_CTRL    = 2'd1;
   localparam logic [1:0] OFF_STATUS  = 2'd2;
   localparam logic [1:0] OFF_DIVISOR = 2'd3;

   // CTRL bit positions
   localparam int CTRL_TXEN = 0;
   localparam int CTRL_IE   = 1;

   // STATUS bit positions; COUNT occupies [STAT_COUNT +: 5]
   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_COUNT = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   // A programmed divisor of 0 behaves as 1 clock per bit
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_tx_dev_fifo.sv
// Byte FIFO with first-word-fall-through head output. A push while full is
// accepted only if a pop happens on the same edge.
module uart_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [7:0]                    wdata,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [7:0]                    rdata
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; reset discards everything queued
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, FIFO front end,
// frame FSM with bit-period down-counter, and level IRQ on drain.
module uart_tx_dev
   import uart_defs::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        txd,
   output logic        IRQ
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    ctrl;
   logic [15:0]   divisor, div_eff;
   logic          ovf;
   tx_state_t     state, state_nxt;
   logic [15:0]   cnt, cnt_nxt, reload, reload_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [7:0]    shift_q, shift_nxt;
   logic          txd_nxt, pop, start_frame, period_end;
   logic          full, empty, busy;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_rdata;
   logic          wr_data, wr_ctrl, wr_status, wr_div;
   logic [31:0]   status;
   logic          unused_bits;

   // Only the low word-offset bits and the low half of Din carry meaning
   assign unused_bits = ^{Addr[29:2], Din[31:16]};

   assign wr_data   = WE && (Addr[1:0] == OFF_DATA);
   assign wr_ctrl   = WE && (Addr[1:0] == OFF_CTRL);
   assign wr_status = WE && (Addr[1:0] == OFF_STATUS);
   assign wr_div    = WE && (Addr[1:0] == OFF_DIVISOR);

   assign div_eff    = eff_div(divisor);
   assign busy       = (state != S_IDLE);
   assign period_end = (cnt == 16'd0);
   assign IRQ        = ctrl[CTRL_IE] & empty & ~busy;

   uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_data),
      .pop   (pop),
      .wdata (Din[7:0]),
      .full  (full),
      .empty (empty),
      .count (fifo_count),
      .rdata (fifo_rdata)
   );

   // Software-visible registers; OVF is sticky until any STATUS write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl    <= 2'b00;
         divisor <= DIV_RESET;
         ovf     <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl    <= Din[1:0];
         if (wr_div)  divisor <= Din[15:0];
         if (wr_status)                      ovf <= 1'b0;
         else if (wr_data && full && !pop)   ovf <= 1'b1;
      end
   end

   // Frame sequencing: next state, next txd, counters and FIFO pop
   always_comb begin
      state_nxt   = state;
      txd_nxt     = txd;
      shift_nxt   = shift_q;
      bit_nxt     = bit_cnt;
      cnt_nxt     = cnt;
      reload_nxt  = reload;
      pop         = 1'b0;
      start_frame = 1'b0;
      case (state)
         S_IDLE: begin
            if (ctrl[CTRL_TXEN] && !empty) start_frame = 1'b1;
         end
         S_START: begin
            if (period_end) begin
               state_nxt = S_DATA;
               txd_nxt   = shift_q[0];
               shift_nxt = shift_q >> 1;
               bit_nxt   = 3'd0;
               cnt_nxt   = reload - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (period_end) begin
               cnt_nxt = reload - 16'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = S_STOP;
                  txd_nxt   = 1'b1;
               end else begin
                  txd_nxt   = shift_q[0];
                  shift_nxt = shift_q >> 1;
                  bit_nxt   = bit_cnt + 3'd1;
               end
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (period_end) begin
               if (ctrl[CTRL_TXEN] && !empty) start_frame = 1'b1;
               else                           state_nxt   = S_IDLE;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // Frame start shares one path from IDLE and from the end of STOP,
      // which is what makes back-to-back frames gap-free
      if (start_frame) begin
         pop        = 1'b1;
         state_nxt  = S_START;
         txd_nxt    = 1'b0;
         shift_nxt  = fifo_rdata;
         reload_nxt = div_eff;
         cnt_nxt    = div_eff - 16'd1;
         bit_nxt    = 3'd0;
      end
   end

   // Control state: FSM, line output and counters; txd idles high in reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         txd     <= 1'b1;
         cnt     <= 16'd0;
         bit_cnt <= 3'd0;
      end else begin
         state   <= state_nxt;
         txd     <= txd_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_nxt;
      end
   end

   // Frame data path: shift register and the divisor latched at frame start
   always_ff @(posedge clk) begin
      shift_q <= shift_nxt;
      reload  <= reload_nxt;
   end

   // STATUS word assembly
   always_comb begin
      status                    = 32'd0;
      status[STAT_BUSY]         = busy;
      status[STAT_FULL]         = full;
      status[STAT_EMPTY]        = empty;
      status[STAT_OVF]          = ovf;
      status[STAT_COUNT +: 5]   = 5'(fifo_count);
   end

   // Combinational read mux; DATA reads as zero
   always_comb begin
      case (Addr[1:0])
         OFF_CTRL:    Dout = {30'd0, ctrl};
         OFF_STATUS:  Dout = status;
         OFF_DIVISOR: Dout = {16'd0, divisor};
         default:     Dout = 32'd0;
      endcase
   end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter peripheral on the system bridge, alongside the two timers. It accepts bytes written by the CPU through the bridge's device port (Addr/WE/Din/Dout), buffers them in a small FIFO, and serialises them as 8N1 frames on `txd`. A level IRQ is raised when the transmitter drains; it drives `HWInt[3]` into CP0. The bridge decodes it at 0x0000_7F30–0x0000_7F3F.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; power of two, 2–16.
- `DIV_RESET`, 16'd16: reset value of DIVISOR, in clocks per bit.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Addr`  in  30  word address (byte address [31:2]); only `Addr[1:0]` (byte offsets 0x0/0x4/0x8/0xC) are decoded.
- `WE`  in  1  write strobe, sampled on the rising edge.
- `Din`  in  32  write data.
- `Dout`  out  32  combinational read data for the register at `Addr`.
- `txd`  out  1  serial output; idles high.
- `IRQ`  out  1  level interrupt request.

## Operation
- Registers (by offset):
  - 0x0 DATA: a write pushes `Din[7:0]`; a read returns 0.
  - 0x4 CTRL, R/W: bit0 TXEN, bit1 IE; other bits read 0.
  - 0x8 STATUS, read-only: bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[8:4] COUNT. Any write to 0x8 clears OVF.
  - 0xC DIVISOR, R/W: bits[15:0]; the value 0 is treated as 1.
- Push when FULL: the byte is dropped and OVF is set, unless a pop occurs on the same edge, in which case the push is accepted.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE → START when TXEN=1 and the FIFO is non-empty. On that edge: pop into an 8-bit shift register, latch DIVISOR into the bit-period reload, set `txd`←0, set the bit counter to 0.
  - START → DATA after one bit period; `txd`←shift[0].
  - DATA shifts LSB-first. After the 8th bit period it goes to STOP with `txd`←1.
  - STOP ends after one bit period:
    - If TXEN=1 and the FIFO is non-empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- A bit period is a down-counter of DIV clocks, where DIV is the value latched at frame start. Writing DIVISOR mid-frame affects the next frame only.
- Clearing TXEN mid-frame lets the current frame finish; no further pops occur.
- `IRQ` = IE & EMPTY & ~BUSY, combinational from registers.
- Reset values:
  - `txd`=1, `IRQ`=0.
  - FSM IDLE, FIFO empty, COUNT 0, OVF 0, CTRL 0, DIVISOR=`DIV_RESET`.
  - `Dout` reflects these values.
- Reset asserted mid-frame: `txd` returns to 1 immediately (asynchronous) and FIFO contents are discarded.

## Timing
- `txd` is a flop output; there is no combinational path from bus to `txd`.
- Write to DATA at edge E0 with TXEN=1 and FSM IDLE: the start bit (`txd`=0) begins at E1.
- Frame length is 10·DIV clocks, covering start, d0..d7 and stop. Each bit holds for exactly DIV clocks.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- STATUS/COUNT reflect a push or pop on the cycle after the edge. `Dout` reflects the same-cycle register state (read-before-write).
- `IRQ` deasserts the cycle after a DATA push, and asserts the cycle after the FSM reaches IDLE with the FIFO empty.

## Structure
- Shared header/package `uart_defs`:
  - register offsets;
  - CTRL/STATUS bit positions;
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3).
- The bridge uses the same offsets for address decode.
- Sub-module `uart_fifo`: synchronous FIFO parameterised by `FIFO_DEPTH`, width 8.
  - Inputs: push, pop.
  - Outputs: full, empty, count, rdata (head, first-word-fall-through).
- Top-level `uart_tx_dev` holds the register file, the FSM, the bit/period counters and the IRQ logic.

## Test plan
- Reset, then read all registers: STATUS=0x004 (EMPTY), DIVISOR=16, CTRL=0, `txd`=1, `IRQ`=0.
- DIV=4, TXEN=1, write 0xA5: `txd` low from E1 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then high. BUSY clears after 40 clocks.
- TXEN=0, write 5 bytes with depth 4: COUNT=4, FULL=1, OVF=1; 5th byte dropped. Write STATUS → OVF=0. Set TXEN: 4 frames with no gaps (160 clocks at DIV=4).
- IE=1, send one byte: `IRQ` falls the cycle after the push and rises the cycle after the stop bit ends. Clearing IE drops `IRQ` immediately.
- Mid-frame DIVISOR change 4→8: the current frame still uses 4-clock bits; the queued next frame uses 8-clock bits.
- Assert `reset` during data bit 3: `txd`=1 asynchronously, FIFO empty, STATUS=0x004 after release.
